// File: rtl/binario_a_bcd_pkg.sv
// Shared constants and types for the seven-segment display path.
package binario_a_bcd_pkg;

  // Converter FSM states
  typedef enum logic [1:0] {
    REPOSO   = 2'd0,
    DESPLAZA = 2'd1,
    FIN      = 2'd2
  } estado_t;

  localparam int BCD_W     = 4;
  localparam int N_DIGITOS = 4;
  localparam int MAX_DEC   = 9999;

  // Digit value shown on every position when the input does not fit
  localparam logic [BCD_W-1:0] DIGITO_SAT = 4'd9;

endpackage

// File: rtl/corrector_suma3.sv
// Double-dabble nibble correction: adds 3 to a BCD nibble that is 5 or more.
module corrector_suma3
  import binario_a_bcd_pkg::*;
(
  input  logic [BCD_W-1:0] nibble,
  output logic [BCD_W-1:0] corregido
);

  // Inputs never exceed 9, so the sum stays within 4 bits
  always_comb begin
    corregido = (nibble >= 4'd5) ? nibble + 4'd3 : nibble;
  end

endmodule

// File: rtl/binario_a_bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3, one bit per clock).
//
// state    | meaning
// ---------+-----------------------------------------------------------
// REPOSO   | idle, waiting for i_Inicio
// DESPLAZA | one correction + shift per cycle, BIN_W cycles in total
// FIN      | one cycle, o_Listo high, may accept a new start
module binario_a_bcd
  import binario_a_bcd_pkg::*;
#(
  parameter int BIN_W = 14
) (
  input  logic             i_Clk,
  input  logic             i_Rst,
  input  logic             i_Inicio,
  input  logic [BIN_W-1:0] i_Binario,
  output logic [3:0]       o_Datos1,
  output logic [3:0]       o_Datos2,
  output logic [3:0]       o_Datos3,
  output logic [3:0]       o_Datos4,
  output logic             o_Ocupado,
  output logic             o_Listo,
  output logic             o_Desborde
);

  localparam int CNT_W = $clog2(BIN_W);
  localparam int ACC_W = BCD_W * N_DIGITOS;

  estado_t          estado, estado_sig;
  logic [BIN_W-1:0] bin_q;
  logic [ACC_W-1:0] acc_q;
  logic [ACC_W-1:0] acc_corr;
  logic [ACC_W-1:0] acc_sig;
  logic [CNT_W-1:0] cnt_q;
  logic             desb_q;
  logic             desb_in;
  logic             acepta;
  logic             ultimo;

  for (genvar g = 0; g < N_DIGITOS; g++) begin : g_corr
    corrector_suma3 u_corr (
      .nibble   (acc_q[g*BCD_W +: BCD_W]),
      .corregido(acc_corr[g*BCD_W +: BCD_W])
    );
  end

  // Accumulator after this cycle's correction and shift; top BCD bit beyond 16 is dropped
  assign acc_sig = {acc_corr[ACC_W-2:0], bin_q[BIN_W-1]};

  // Narrower inputs can never exceed 9999, so the compare folds away
  assign desb_in = (BIN_W >= 14) ? (32'(i_Binario) > 32'(MAX_DEC)) : 1'b0;

  // State register
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) estado <= REPOSO;
    else        estado <= estado_sig;
  end

  // Next-state logic and control strobes
  always_comb begin
    estado_sig = estado;
    acepta     = 1'b0;
    ultimo     = 1'b0;
    case (estado)
      REPOSO: begin
        if (i_Inicio) begin
          acepta     = 1'b1;
          estado_sig = DESPLAZA;
        end
      end
      DESPLAZA: begin
        if (cnt_q == '0) begin
          ultimo     = 1'b1;
          estado_sig = FIN;
        end
      end
      FIN: begin
        if (i_Inicio) begin
          acepta     = 1'b1;
          estado_sig = DESPLAZA;
        end else begin
          estado_sig = REPOSO;
        end
      end
      default: estado_sig = REPOSO;
    endcase
  end

  // Datapath; results load on the last shift edge so they are visible during FIN
  always_ff @(posedge i_Clk or negedge i_Rst) begin
    if (!i_Rst) begin
      bin_q      <= '0;
      acc_q      <= '0;
      cnt_q      <= '0;
      desb_q     <= 1'b0;
      o_Datos1   <= '0;
      o_Datos2   <= '0;
      o_Datos3   <= '0;
      o_Datos4   <= '0;
      o_Ocupado  <= 1'b0;
      o_Listo    <= 1'b0;
      o_Desborde <= 1'b0;
    end else begin
      o_Listo <= ultimo;
      if (acepta) begin
        bin_q     <= i_Binario;
        acc_q     <= '0;
        cnt_q     <= CNT_W'(BIN_W - 1);
        desb_q    <= desb_in;
        o_Ocupado <= 1'b1;
      end else if (estado == DESPLAZA) begin
        bin_q <= {bin_q[BIN_W-2:0], 1'b0};
        acc_q <= acc_sig;
        if (ultimo) begin
          o_Ocupado  <= 1'b0;
          o_Desborde <= desb_q;
          o_Datos1   <= desb_q ? DIGITO_SAT : acc_sig[0*BCD_W +: BCD_W];
          o_Datos2   <= desb_q ? DIGITO_SAT : acc_sig[1*BCD_W +: BCD_W];
          o_Datos3   <= desb_q ? DIGITO_SAT : acc_sig[2*BCD_W +: BCD_W];
          o_Datos4   <= desb_q ? DIGITO_SAT : acc_sig[3*BCD_W +: BCD_W];
        end else begin
          cnt_q <= cnt_q - 1'b1;
        end
      end
    end
  end

endmodule
